mul_share_ctrl: RTL

- Sequencing controller and round-robin arbiter that shares one unsigned sequential multiplier between two requesters.
- Accepts a request, latches its operands and pulses the multiplier's enable.
- Waits for the multiplier's ready, captures the 2N+1-bit result and returns it tagged with the requester ID.
- A timeout guards against a hung multiplier and flushes it.

---
 rtl/mul_share_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mul_share_ctrl.sv
// Round-robin sequencer sharing one sequential multiplier between two requesters.
// Issues the operands, waits for ready (or a timeout that flushes the multiplier) and returns a tagged result.
module mul_share_ctrl #(
   parameter int N       = 32,
   parameter int TIMEOUT = 48,
   parameter int CW      = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic [N-1:0] a0,
   input  logic [N-1:0] b0,
   output logic         ack0,
   input  logic         req1,
   input  logic [N-1:0] a1,
   input  logic [N-1:0] b1,
   output logic         ack1,
   output logic         res_valid,
   output logic         res_id,
   output logic [N-1:0] res_hi,
   output logic [N-1:0] res_lo,
   output logic         res_cout,
   output logic         res_err,
   output logic         busy,
   output logic         mul_reset,
   output logic         mul_enable,
   output logic [N-1:0] mul_multiplier,
   output logic [N-1:0] mul_multiplicand,
   input  logic         mul_ready,
   input  logic [N-1:0] mul_product_upper,
   input  logic [N-1:0] mul_product_lower,
   input  logic         mul_cout
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

   localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

   state_t         state_q, state_d;
   logic           last_grant_q, last_grant_d;
   logic           id_q, id_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   mult_q, mult_d, mcand_q, mcand_d;
   logic           enable_q, enable_d;
   logic           ack0_q, ack0_d, ack1_q, ack1_d;
   logic           res_valid_q, res_valid_d, res_err_q, res_err_d;
   logic           res_id_q, res_id_d, res_cout_q, res_cout_d;
   logic [N-1:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
   logic           busy_q, busy_d;
   logic           grant;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      cnt_d        = cnt_q;
      mult_d       = mult_q;
      mcand_d      = mcand_q;
      enable_d     = 1'b0;
      ack0_d       = 1'b0;
      ack1_d       = 1'b0;
      res_valid_d  = 1'b0;
      res_err_d    = 1'b0;
      res_id_d     = res_id_q;
      res_hi_d     = res_hi_q;
      res_lo_d     = res_lo_q;
      res_cout_d   = res_cout_q;
      grant        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               // On contention the requester that did not win last time goes first
               grant        = (req0 && req1) ? ~last_grant_q : req1;
               last_grant_d = grant;
               id_d         = grant;
               mult_d       = grant ? a1 : a0;
               mcand_d      = grant ? b1 : b0;
               ack0_d       = ~grant;
               ack1_d       = grant;
               state_d      = S_ISSUE;
            end
         end
         S_ISSUE: begin
            enable_d = 1'b1;
            cnt_d    = '0;
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            // Ready seen in the first WAIT cycle may be left over from the previous operation
            if (mul_ready && (cnt_q != '0)) begin
               res_hi_d    = mul_product_upper;
               res_lo_d    = mul_product_lower;
               res_cout_d  = mul_cout;
               res_id_d    = id_q;
               res_valid_d = 1'b1;
               state_d     = S_IDLE;
            end else if (cnt_q == TMO) begin
               res_hi_d    = '0;
               res_lo_d    = '0;
               res_cout_d  = 1'b0;
               res_id_d    = id_q;
               res_valid_d = 1'b1;
               res_err_d   = 1'b1;
               state_d     = S_FLUSH;
            end
         end
         S_FLUSH: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         cnt_q        <= '0;
         mult_q       <= '0;
         mcand_q      <= '0;
         enable_q     <= 1'b0;
         ack0_q       <= 1'b0;
         ack1_q       <= 1'b0;
         res_valid_q  <= 1'b0;
         res_err_q    <= 1'b0;
         res_id_q     <= 1'b0;
         res_hi_q     <= '0;
         res_lo_q     <= '0;
         res_cout_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         cnt_q        <= cnt_d;
         mult_q       <= mult_d;
         mcand_q      <= mcand_d;
         enable_q     <= enable_d;
         ack0_q       <= ack0_d;
         ack1_q       <= ack1_d;
         res_valid_q  <= res_valid_d;
         res_err_q    <= res_err_d;
         res_id_q     <= res_id_d;
         res_hi_q     <= res_hi_d;
         res_lo_q     <= res_lo_d;
         res_cout_q   <= res_cout_d;
         busy_q       <= busy_d;
      end
   end

   assign ack0             = ack0_q;
   assign ack1             = ack1_q;
   assign res_valid        = res_valid_q;
   assign res_err          = res_err_q;
   assign res_id           = res_id_q;
   assign res_hi           = res_hi_q;
   assign res_lo           = res_lo_q;
   assign res_cout         = res_cout_q;
   assign busy             = busy_q;
   assign mul_enable       = enable_q;
   assign mul_multiplier   = mult_q;
   assign mul_multiplicand = mcand_q;
   assign mul_reset        = reset | (state_q == S_FLUSH);

endmodule
